// File: rtl/seq_detector_pkg.sv
// -----------------------------------------------------------------------------
// seq_det_defs
//   Shared definitions for the 1011 serial sequence detector: state codes,
//   the pattern constant and a legality helper. Imported by the RTL and by
//   the testbench so both agree on the encoding.
// -----------------------------------------------------------------------------
package seq_det_defs;

  localparam int STATE_W     = 3;
  localparam int PATTERN_LEN = 4;

  // Pattern is shifted in MSB first: 1, 0, 1, 1.
  localparam logic [PATTERN_LEN-1:0] PATTERN = 4'b1011;

  // State codes; 101..111 are illegal and recover to S0.
  localparam logic [STATE_W-1:0] S0 = 3'b000;  // idle
  localparam logic [STATE_W-1:0] S1 = 3'b001;  // seen "1"
  localparam logic [STATE_W-1:0] S2 = 3'b010;  // seen "10"
  localparam logic [STATE_W-1:0] S3 = 3'b011;  // seen "101"
  localparam logic [STATE_W-1:0] S4 = 3'b100;  // seen "1011"

  function automatic logic is_legal_state(input logic [STATE_W-1:0] s);
    return (s <= S4);
  endfunction

endpackage

// File: rtl/seq_detector_dff.sv
// -----------------------------------------------------------------------------
// dff
//   Single-bit D flip-flop with asynchronous active-low reset to 0.
//   Ports:
//     clk   - rising-edge clock
//     reset - asynchronous active-low reset
//     d     - next value
//     q     - stored value
// -----------------------------------------------------------------------------
module dff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  // NOTE: sequential state is always written with non-blocking assignments
  // so every flop samples the pre-edge value of its inputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) q <= 1'b0;
    else        q <= d;
  end

endmodule

// File: rtl/seq_detector.sv
// -----------------------------------------------------------------------------
// seq_detector
//   Moore FSM detecting the serial pattern 1,0,1,1 on d_in (sampled only when
//   in_valid=1). The three state bits live in dff instances; match is a
//   registered one-cycle pulse coinciding with the cycle the FSM sits in S4
//   after a valid final bit, and match_count is a saturating tally of pulses.
//   Parameters:
//     CNT_W   - width of match_count
//     OVERLAP - 1: a completed 1011 may seed the next match, 0: it may not
//   Ports:
//     clk         - rising-edge clock
//     reset       - asynchronous active-low reset
//     in_valid    - qualifies d_in
//     d_in        - serial data bit
//     match       - one-cycle pulse when 1011 completes
//     match_count - saturating match count
//     state_out   - current state code (debug)
// -----------------------------------------------------------------------------
module seq_detector
  import seq_det_defs::*;
#(
  parameter int CNT_W   = 8,
  parameter int OVERLAP = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic               d_in,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  output logic [STATE_W-1:0] state_out
);

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] next_state;
  logic               enter_s4;

  // NOTE: every signal written in an always_comb block gets a default first,
  // so no path can leave it unassigned and infer a latch.
  always_comb begin
    next_state = state;
    if (!is_legal_state(state)) begin
      // Corrupted code: recover regardless of in_valid.
      next_state = S0;
    end else if (in_valid) begin
      case (state)
        S0:      next_state = d_in ? S1 : S0;
        S1:      next_state = d_in ? S1 : S2;
        S2:      next_state = d_in ? S3 : S0;
        S3:      next_state = d_in ? S4 : S2;
        default: begin
          // S4: with overlap the trailing "1" or "10" of 1011 is kept.
          if (OVERLAP != 0) next_state = d_in ? S1 : S2;
          else              next_state = d_in ? S1 : S0;
        end
      endcase
    end
  end

  for (genvar i = 0; i < STATE_W; i++) begin : g_state_bit
    dff u_dff (
      .clk   (clk),
      .reset (reset),
      .d     (next_state[i]),
      .q     (state[i])
    );
  end

  assign state_out = state;

  // S4 is only reachable from S3 on a valid 1, so this is true exactly on the
  // edge that completes the pattern; holding in S4 never re-fires it.
  assign enter_s4 = in_valid && (next_state == S4);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      match       <= 1'b0;
      match_count <= '0;
    end else begin
      match <= enter_s4;
      if (enter_s4 && (match_count != {CNT_W{1'b1}})) begin
        match_count <= match_count + 1'b1;
      end
    end
  end

endmodule
